ec_send_arbiter: RTL and testbench
==================================

// Module: ec_send_arbiter
// PURPOSE
//   Shares the single ec send path among N_REQ word producers (e.g. game-state packer, input
//   reporter). Round-robin arbitration; latches the granted word and drives the ec send handshake.
//   Returns a per-requester completion pulse. Sits between producers and ec valid_send_i/data_send_i/ack_send_i.
// PARAMETERS
//   N_REQ    2     number of requesters (2..8)
//   DW       32    word width; matches ec send data width
//   GAP      0     idle cycles forced after each completed word (0..255)
//   TIMEOUT  1023  watchdog limit in cycles; used only with EC_ARB_WATCHDOG_EN
// PORTS
//   CLK          in   1         system clock
//   RST          in   1         asynchronous reset, active-low
//   req_valid_i  in   N_REQ     per-requester word available; held high until matching req_ack_o
//   req_data_i   in   N_REQ*DW  requester i word in bits [i*DW +: DW]
//   req_ack_o    out  N_REQ     one-cycle pulse: requester i's word accepted by ec
//   ec_valid_o   out  1         word presented to ec (drives valid_send_i)
//   ec_data_o    out  DW        latched granted word (drives data_send_i)
//   ec_ack_i     in   1         ec accepted the word (from ack_send_i)
//   grant_o      out  N_REQ     one-hot current owner; 0 when not in SEND
//   busy_o       out  1         high in SEND or GAP
//   timeout_o    out  1         one-cycle watchdog pulse; constant 0 without EC_ARB_WATCHDOG_EN
// BEHAVIOUR
//   Clocking: single clock CLK; RST asynchronous, active-low. All outputs are registered.
//   Reset values: ec_valid_o=0, ec_data_o=0, req_ack_o=0, grant_o=0, busy_o=0, timeout_o=0,
//     state=IDLE, rr pointer=0, gap and watchdog counters=0.
//   States:
//     IDLE: if any req_valid_i, pick the first set bit searching from the rr pointer upward,
//       wrapping modulo N_REQ. Latch that requester's data into ec_data_o. Set grant_o and
//       ec_valid_o. Go to SEND. Latency: req_valid_i high at edge t -> ec_valid_o high after edge t+1.
//     SEND: hold ec_valid_o and ec_data_o stable. Transfer completes on a cycle with
//       ec_valid_o && ec_ack_i. On completion, at the next edge:
//       - ec_valid_o=0, grant_o=0;
//       - req_ack_o[owner]=1 for exactly one cycle;
//       - rr pointer = (owner+1) mod N_REQ;
//       - go to GAP if GAP>0, else IDLE.
//     GAP: count GAP cycles, then go to IDLE. The earliest next grant is GAP+1 cycles after
//       the req_ack_o pulse.
//   Boundary cases:
//     - ec_ack_i while not in SEND is ignored.
//     - Owner dropping req_valid_i during SEND (protocol violation): the latched word is still
//       sent and acked.
//     - Requesters are never granted twice in a row while another is valid (strict round-robin).
//     - N_REQ=1 degenerates to a pass-through with a one-cycle registration.
//     - A single requester with GAP=0 achieves one word per 2 cycles plus ec ack latency.
//     - Reset asserted mid-SEND: all outputs drop immediately; the in-flight word is discarded
//       without req_ack_o, and the requester re-requests after release.
// CONFIGURATION
//   EC_ARB_WATCHDOG_EN defined:
//     - A counter runs in SEND. If it reaches TIMEOUT with no ec_ack_i, then at the next edge:
//       ec_valid_o=0, grant_o=0, timeout_o=1 for one cycle, no req_ack_o, rr pointer advances
//       past the owner, state goes to GAP/IDLE.
//     - The owner, still valid, is re-arbitrated later.
//   EC_ARB_WATCHDOG_EN undefined:
//     - SEND waits indefinitely; timeout_o tied 0; no counter is synthesised.
//     - The port list is identical in both builds.
// STRUCTURE
//   Shared header ec_defs.vh:
//     - state encodings EC_ARB_IDLE=2'd0, EC_ARB_SEND=2'd1, EC_ARB_GAP=2'd2;
//     - EC_WORD_W=32 constant used by the ec_* blocks.
//   Sub-module rr_pick: combinational one-hot round-robin picker
//     (inputs req, ptr; output one-hot grant + index).
//   Top level: FSM, data latch, gap/watchdog counters.
// TESTING
//   1. Reset, then req_valid_i=01, ec_ack_i 3 cycles after ec_valid_o rises
//      -> ec_data_o=req0 word, req_ack_o=01 pulse once, grant_o back to 00.
//   2. req_valid_i=11 held, ec_ack_i same cycle as ec_valid_o
//      -> grants alternate 01,10,01,10; each req_ack_o pulses on its turn.
//   3. GAP=3, single requester continuously valid
//      -> exactly 3 cycles between the req_ack_o pulse and the next ec_valid_o rise.
//   4. RST low for 1 cycle mid-SEND
//      -> ec_valid_o=0 immediately, no req_ack_o; after release, requester 0 is granted again
//         (pointer reset to 0).
//   5. With EC_ARB_WATCHDOG_EN and TIMEOUT=16, ec_ack_i never asserted, req_valid_i=11
//      -> timeout_o pulses 17 cycles after grant, next grant goes to requester 1.
//   6. ec_ack_i pulsed while IDLE with no requests -> no outputs change.

Source files
------------

// File: rtl/ec_send_arbiter_pkg.sv
// Shared types and constants for the ec send arbiter: FSM state encoding,
// ec word width and the index-width helper.
package ec_send_arbiter_pkg;

   localparam int EC_WORD_W = 32;

   typedef enum logic [1:0] {
      EC_ARB_IDLE = 2'd0,
      EC_ARB_SEND = 2'd1,
      EC_ARB_GAP  = 2'd2
   } arb_state_t;

   // Width of a requester index; a single requester still needs one bit.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/ec_send_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping modulo N_REQ. Returns a one-hot grant and the matching index.
module ec_send_arbiter_rr_pick
   import ec_send_arbiter_pkg::*;
#(
   parameter int N_REQ = 2,
   parameter int IW    = idx_w(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IW-1:0]    ptr,
   output logic [N_REQ-1:0] grant,
   output logic [IW-1:0]    idx,
   output logic             any
);

   logic [IW-1:0] slot;

   // NOTE: every signal written here gets a default first; a path that leaves
   // one unassigned would infer a latch.
   always_comb begin
      grant = '0;
      idx   = '0;
      slot  = '0;
      any   = |req;
      // Scan from the farthest slot back to ptr so the nearest hit wins.
      for (int k = N_REQ - 1; k >= 0; k--) begin
         slot = IW'((int'(ptr) + k) % N_REQ);
         if (req[slot]) begin
            grant       = '0;
            grant[slot] = 1'b1;
            idx         = slot;
         end
      end
   end

endmodule

// File: rtl/ec_send_arbiter.sv
// Round-robin arbiter sharing the ec send path among N_REQ word producers.
// Optional watchdog on a stalled send: define EC_ARB_WATCHDOG_EN.
module ec_send_arbiter
   import ec_send_arbiter_pkg::*;
#(
   parameter int N_REQ   = 2,
   parameter int DW      = EC_WORD_W,
   parameter int GAP     = 0,
   parameter int TIMEOUT = 1023
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic [N_REQ-1:0]    req_valid_i,
   input  logic [N_REQ*DW-1:0] req_data_i,
   output logic [N_REQ-1:0]    req_ack_o,
   output logic                ec_valid_o,
   output logic [DW-1:0]       ec_data_o,
   input  logic                ec_ack_i,
   output logic [N_REQ-1:0]    grant_o,
   output logic                busy_o,
   output logic                timeout_o
);

   localparam int IW = idx_w(N_REQ);
   localparam int GW = 8;

   if (N_REQ < 1 || N_REQ > 8 || GAP < 0 || GAP > 255 || TIMEOUT < 1) begin : g_param_check
      $error("ec_send_arbiter: parameter out of range");
   end

   arb_state_t       state_q, state_d;
   logic [IW-1:0]    ptr_q, ptr_d;
   logic [IW-1:0]    owner_q, owner_d;
   logic [GW-1:0]    gap_q, gap_d;

   logic [N_REQ-1:0] pick_grant;
   logic [IW-1:0]    pick_idx;
   logic             pick_any;
   logic [DW-1:0]    pick_data;

   logic             done;
   logic             expired;

   logic             ec_valid_d;
   logic [DW-1:0]    ec_data_d;
   logic [N_REQ-1:0] req_ack_d;
   logic [N_REQ-1:0] grant_d;
   logic             busy_d;
   logic             timeout_d;

   ec_send_arbiter_rr_pick #(
      .N_REQ (N_REQ),
      .IW    (IW)
   ) u_pick (
      .req   (req_valid_i),
      .ptr   (ptr_q),
      .grant (pick_grant),
      .idx   (pick_idx),
      .any   (pick_any)
   );

   assign pick_data = req_data_i[pick_idx * DW +: DW];

   // ec_valid_o is high exactly while in SEND, so an ack anywhere else is ignored.
   assign done = (state_q == EC_ARB_SEND) && ec_ack_i;

`ifdef EC_ARB_WATCHDOG_EN
   localparam int WW = $clog2(TIMEOUT + 1);

   logic [WW-1:0] wd_q;

   assign expired = (state_q == EC_ARB_SEND) && !ec_ack_i && (wd_q == WW'(TIMEOUT));

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST)                       wd_q <= '0;
      else if (state_q != EC_ARB_SEND) wd_q <= '0;
      else if (!expired)              wd_q <= wd_q + 1'b1;
   end
`else
   assign expired = 1'b0;
`endif

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q    <= EC_ARB_IDLE;
         ptr_q      <= '0;
         owner_q    <= '0;
         gap_q      <= '0;
         ec_valid_o <= 1'b0;
         ec_data_o  <= '0;
         req_ack_o  <= '0;
         grant_o    <= '0;
         busy_o     <= 1'b0;
         timeout_o  <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         owner_q    <= owner_d;
         gap_q      <= gap_d;
         ec_valid_o <= ec_valid_d;
         ec_data_o  <= ec_data_d;
         req_ack_o  <= req_ack_d;
         grant_o    <= grant_d;
         busy_o     <= busy_d;
         timeout_o  <= timeout_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      owner_d = owner_q;
      gap_d   = gap_q;
      unique case (state_q)
         EC_ARB_IDLE: begin
            if (pick_any) begin
               state_d = EC_ARB_SEND;
               owner_d = pick_idx;
            end
         end
         EC_ARB_SEND: begin
            if (done || expired) begin
               ptr_d   = (owner_q == IW'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
               state_d = (GAP > 0) ? EC_ARB_GAP : EC_ARB_IDLE;
               gap_d   = '0;
            end
         end
         EC_ARB_GAP: begin
            if (gap_q == GW'(GAP - 1)) begin
               state_d = EC_ARB_IDLE;
               gap_d   = '0;
            end else begin
               gap_d = gap_q + 1'b1;
            end
         end
         default: state_d = EC_ARB_IDLE;
      endcase
   end

   // Outputs are registered from the next state, so they line up with state_q.
   always_comb begin
      ec_valid_d = (state_d == EC_ARB_SEND);
      grant_d    = '0;
      if (state_d == EC_ARB_SEND)
         grant_d = (state_q == EC_ARB_SEND) ? grant_o : pick_grant;
      ec_data_d  = (state_q == EC_ARB_IDLE && state_d == EC_ARB_SEND) ? pick_data : ec_data_o;
      req_ack_d  = done ? grant_o : '0;
      busy_d     = (state_d != EC_ARB_IDLE);
      timeout_d  = expired;
   end

endmodule

// File: tb/tb_ec_send_arbiter.sv
// Self-checking bench for ec_send_arbiter against a cycle-level behavioural model;
// the watchdog scenario runs when EC_ARB_WATCHDOG_EN is defined.
module tb_ec_send_arbiter;

   localparam int N   = 3;
   localparam int DW  = 32;
   localparam int GAP = 2;
   localparam int TMO = 16;
   localparam int VW  = 3 + DW + 2 * N;

   logic          clk       = 1'b0;
   logic          rst_n     = 1'b0;
   logic [N-1:0]  req_valid = '0;
   logic [N*DW-1:0] req_data = '0;
   logic          ec_ack    = 1'b0;
   logic [N-1:0]  req_ack;
   logic [N-1:0]  grant;
   logic          ec_valid;
   logic [DW-1:0] ec_data;
   logic          busy;
   logic          timeout;

   int vectors     = 0;
   int miscompares = 0;

   // Reference model: owner index (-1 = none), remaining gap cycles, rr pointer.
   int            m_owner;
   int            m_gap;
   int            m_ptr;
   int            m_wd;
   logic [DW-1:0] m_word;
   logic [N-1:0]  m_ack;
   logic          m_to;

   always #5 clk = ~clk;

   ec_send_arbiter #(
      .N_REQ   (N),
      .DW      (DW),
      .GAP     (GAP),
      .TIMEOUT (TMO)
   ) dut (
      .CLK         (clk),
      .RST         (rst_n),
      .req_valid_i (req_valid),
      .req_data_i  (req_data),
      .req_ack_o   (req_ack),
      .ec_valid_o  (ec_valid),
      .ec_data_o   (ec_data),
      .ec_ack_i    (ec_ack),
      .grant_o     (grant),
      .busy_o      (busy),
      .timeout_o   (timeout)
   );

   task automatic model_reset();
      m_owner = -1;
      m_gap   = 0;
      m_ptr   = 0;
      m_wd    = 0;
      m_word  = '0;
      m_ack   = '0;
      m_to    = 1'b0;
   endtask

   task automatic model_release();
      m_ptr   = (m_owner + 1) % N;
      m_owner = -1;
      m_gap   = GAP;
   endtask

   // Applied at each active edge with the inputs the DUT samples there.
   task automatic model_edge();
      bit found;
      m_ack = '0;
      m_to  = 1'b0;
      if (m_owner >= 0) begin
         if (ec_ack) begin
            m_ack[m_owner] = 1'b1;
            model_release();
         end
`ifdef EC_ARB_WATCHDOG_EN
         else if (m_wd == TMO) begin
            m_to = 1'b1;
            model_release();
         end else begin
            m_wd++;
         end
`endif
      end else if (m_gap > 0) begin
         m_gap--;
      end else begin
         found = 1'b0;
         for (int k = 0; k < N; k++) begin
            int j;
            j = (m_ptr + k) % N;
            if (!found && req_valid[j]) begin
               found   = 1'b1;
               m_owner = j;
               m_word  = req_data[j*DW +: DW];
               m_wd    = 0;
            end
         end
      end
   endtask

   function automatic logic [VW-1:0] obs_vec();
      return {ec_valid, ec_data, req_ack, grant, busy, timeout};
   endfunction

   function automatic logic [VW-1:0] exp_vec();
      logic [N-1:0] g;
      g = '0;
      if (m_owner >= 0) g = N'(1) << m_owner;
      return {(m_owner >= 0), m_word, m_ack, g, (m_owner >= 0) || (m_gap > 0), m_to};
   endfunction

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic set_req(input int i, input logic v, input logic [DW-1:0] w);
      req_valid[i]         = v;
      req_data[i*DW +: DW] = w;
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      req_valid = '0;
      ec_ack    = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // Requesters react to the ack pulse of the cycle just ended, before the next edge.
   task automatic drive_requesters(input int keep_pct, input int new_pct, input int drop_pct);
      for (int i = 0; i < N; i++) begin
         if (m_ack[i]) begin
            if ($urandom_range(99) < keep_pct) set_req(i, 1'b1, $urandom);
            else                               set_req(i, 1'b0, $urandom);
         end else if (!req_valid[i]) begin
            if ($urandom_range(99) < new_pct) set_req(i, 1'b1, $urandom);
         end else if (m_owner == i && $urandom_range(99) < drop_pct) begin
            req_valid[i] = 1'b0;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      vectors++;
      if (obs_vec() !== '0) begin
         miscompares++;
         $display("FAIL reset_values: dut=%h want=0", obs_vec());
      end
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         vectors++;
         if (obs_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL reset_idle c%0d: dut=%h model=%h", c, obs_vec(), exp_vec());
         end
      end
   endtask

   task automatic test_single();
      int acks;
      do_reset();
      acks = 0;
      set_req(0, 1'b1, 32'hA5A5_0001);
      tick();
      vectors++;
      if (ec_valid !== 1'b1 || ec_data !== 32'hA5A5_0001) begin
         miscompares++;
         $display("FAIL single_grant: valid=%b data=%h want 1/a5a50001", ec_valid, ec_data);
      end
      for (int c = 0; c < 8; c++) begin
         ec_ack = (c == 2);
         tick();
         if (req_ack[0]) acks++;
         vectors++;
         if (obs_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL single c%0d: dut=%h model=%h", c, obs_vec(), exp_vec());
         end
         if (m_ack[0]) req_valid[0] = 1'b0;
      end
      ec_ack = 1'b0;
      vectors++;
      if (acks != 1) begin
         miscompares++;
         $display("FAIL single_ack_count: got %0d want 1", acks);
      end
   endtask

   task automatic test_alternate();
      logic [N-1:0] seen [$];
      logic         prev_valid;
      logic [N-1:0] want;
      do_reset();
      set_req(0, 1'b1, $urandom);
      set_req(1, 1'b1, $urandom);
      ec_ack     = 1'b1;
      prev_valid = 1'b0;
      for (int c = 0; c < 60 && seen.size() < 4; c++) begin
         tick();
         vectors++;
         if (obs_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL alternate c%0d: dut=%h model=%h", c, obs_vec(), exp_vec());
         end
         if (ec_valid && !prev_valid) seen.push_back(grant);
         prev_valid = ec_valid;
         drive_requesters(100, 0, 0);
      end
      ec_ack = 1'b0;
      for (int k = 0; k < 4; k++) begin
         want = (k % 2 == 0) ? 3'b001 : 3'b010;
         vectors++;
         if (k >= seen.size()) begin
            miscompares++;
            $display("FAIL alternate_seq%0d: no grant seen want %b", k, want);
         end else if (seen[k] !== want) begin
            miscompares++;
            $display("FAIL alternate_seq%0d: got %b want %b", k, seen[k], want);
         end
      end
   endtask

   task automatic test_gap();
      int last_ack;
      int measured;
      logic prev_valid;
      do_reset();
      set_req(1, 1'b1, $urandom);
      ec_ack     = 1'b1;
      last_ack   = -1;
      measured   = 0;
      prev_valid = 1'b0;
      for (int c = 0; c < 80 && measured < 3; c++) begin
         tick();
         vectors++;
         if (obs_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL gap c%0d: dut=%h model=%h", c, obs_vec(), exp_vec());
         end
         if (ec_valid && !prev_valid && last_ack >= 0) begin
            measured++;
            vectors++;
            if (c - last_ack - 1 != GAP) begin
               miscompares++;
               $display("FAIL gap_cycles: got %0d want %0d", c - last_ack - 1, GAP);
            end
         end
         if (req_ack[1]) last_ack = c;
         prev_valid = ec_valid;
         drive_requesters(100, 0, 0);
      end
      ec_ack = 1'b0;
      vectors++;
      if (measured < 3) begin
         miscompares++;
         $display("FAIL gap_budget: got %0d gaps want 3", measured);
      end
   endtask

   task automatic test_reset_mid_send();
      do_reset();
      set_req(0, 1'b1, 32'h0000_00A0);
      tick();
      ec_ack = 1'b1;
      tick();
      ec_ack = 1'b0;
      set_req(0, 1'b1, 32'h0000_00B0);
      set_req(1, 1'b1, 32'h0000_00B1);
      for (int c = 0; c < 10 && m_owner < 0; c++) begin
         tick();
         vectors++;
         if (obs_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL midrst_pre c%0d: dut=%h model=%h", c, obs_vec(), exp_vec());
         end
      end
      vectors++;
      if (grant !== 3'b010) begin
         miscompares++;
         $display("FAIL midrst_ptr: grant=%b want 010", grant);
      end
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      vectors++;
      if (obs_vec() !== '0) begin
         miscompares++;
         $display("FAIL midrst_drop: dut=%h want=0", obs_vec());
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick();
      vectors++;
      if (grant !== 3'b001 || ec_data !== 32'h0000_00B0 || req_ack !== '0) begin
         miscompares++;
         $display("FAIL midrst_regrant: grant=%b data=%h ack=%b want 001/b0/000", grant, ec_data, req_ack);
      end
   endtask

   task automatic test_idle_ack();
      do_reset();
      for (int c = 0; c < 6; c++) begin
         ec_ack = c[0];
         tick();
         vectors++;
         if (obs_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL idle_ack c%0d: dut=%h model=%h", c, obs_vec(), exp_vec());
         end
      end
      ec_ack = 1'b0;
   endtask

   task automatic test_stall();
      int n;
      do_reset();
      set_req(0, 1'b1, $urandom);
      set_req(1, 1'b1, $urandom);
      tick();
      n = 0;
      for (int c = 0; c < 40; c++) begin
         tick();
         n++;
         vectors++;
         if (obs_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL stall c%0d: dut=%h model=%h", c, obs_vec(), exp_vec());
         end
         if (timeout) break;
      end
`ifdef EC_ARB_WATCHDOG_EN
      vectors++;
      if (n != TMO + 1) begin
         miscompares++;
         $display("FAIL watchdog_delay: got %0d want %0d", n, TMO + 1);
      end
      for (int c = 0; c < 10 && !ec_valid; c++) begin
         tick();
         vectors++;
         if (obs_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL watchdog_after c%0d: dut=%h model=%h", c, obs_vec(), exp_vec());
         end
      end
      vectors++;
      if (grant !== 3'b010) begin
         miscompares++;
         $display("FAIL watchdog_regrant: grant=%b want 010", grant);
      end
`else
      vectors++;
      if (ec_valid !== 1'b1 || grant !== 3'b001 || timeout !== 1'b0) begin
         miscompares++;
         $display("FAIL stall_hold: valid=%b grant=%b timeout=%b want 1/001/0", ec_valid, grant, timeout);
      end
`endif
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 600; c++) begin
         ec_ack = ($urandom_range(2) == 0);
         tick();
         vectors++;
         if (obs_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL random c%0d: dut=%h model=%h", c, obs_vec(), exp_vec());
         end
         drive_requesters(50, 30, 3);
      end
      ec_ack = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      model_reset();
      test_reset();
      test_single();
      test_alternate();
      test_gap();
      test_reset_mid_send();
      test_idle_ack();
      test_stall();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
